scan_doubler: RTL and testbench



---
 rtl/scan_doubler.sv | 223 ++++++++++++++++++++++
 tb/tb_scan_doubler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_doubler.sv
// -----------------------------------------------------------------------------
// scan_doubler
//
// Turns the native 15 kHz raster into a 31 kHz progressive raster. Each input
// line is captured into one half of a ping-pong line buffer while the other
// half, which holds the previous line, is read out at twice the pixel rate.
// Every stored line is therefore shown twice per input line period. All logic
// runs on CLK_48M. CLK_6M_I is sampled as data, and its rising edge gives the
// input pixel strobe.
//
// Ports
//   CLK_48M      system clock, rising edge
//   RST          asynchronous active-high reset
//   CLK_6M_I     pixel clock level; a rising edge is an input strobe
//   HSYNC_I      native hsync; a rising edge starts a new line
//   VSYNC_I      native vsync, latched at each line start
//   HBLANK_I     native hblank, stored per pixel in the line buffer
//   VBLANK_I     native vblank, latched at each line start
//   R_I/G_I/B_I  native pixel colour
//   R_O/G_O/B_O  doubled pixel colour, forced to zero while BLANK_O is high
//   HSYNC_O      high for the first OUT_HSYNC_LEN pixels of each output line
//   VSYNC_O      VSYNC_I as latched at the last line start
//   BLANK_O      stored hblank | latched vblank | no completed line yet
//   PIX_CE_O     output pixel strobe, one cycle in every four
//   OVERFLOW_O   sticky; set when an input line reaches the last address
// -----------------------------------------------------------------------------
module scan_doubler #(
    parameter int RGB_WIDTH     = 4,
    parameter int ADDR_WIDTH    = 9,
    parameter int OUT_HSYNC_LEN = 32
) (
    input  logic                 CLK_48M,
    input  logic                 RST,
    input  logic                 CLK_6M_I,
    input  logic                 HSYNC_I,
    input  logic                 VSYNC_I,
    input  logic                 HBLANK_I,
    input  logic                 VBLANK_I,
    input  logic [RGB_WIDTH-1:0] R_I,
    input  logic [RGB_WIDTH-1:0] G_I,
    input  logic [RGB_WIDTH-1:0] B_I,
    output logic [RGB_WIDTH-1:0] R_O,
    output logic [RGB_WIDTH-1:0] G_O,
    output logic [RGB_WIDTH-1:0] B_O,
    output logic                 HSYNC_O,
    output logic                 VSYNC_O,
    output logic                 BLANK_O,
    output logic                 PIX_CE_O,
    output logic                 OVERFLOW_O
);

    // Stored word layout: {hblank, R, G, B}.
    localparam int WORD_W = 3 * RGB_WIDTH + 1;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   HS_LEN    = (ADDR_WIDTH + 1)'(OUT_HSYNC_LEN);

    // ---------------------------------------------------------------------
    // Input side
    // ---------------------------------------------------------------------
    logic                  r_prev_6m;
    logic                  r_prev_hs;
    logic                  r_wr_phase;   // 1: the next input strobe is a skip slot
    logic                  r_line_seen;  // a line start has occurred since reset
    logic                  r_wr_bank;
    logic [ADDR_WIDTH-1:0] r_wr_x;
    logic [ADDR_WIDTH-1:0] r_line_len;
    logic                  r_vsync;
    logic                  r_vblank;
    logic                  r_overflow;

    logic                  w_in_ce;
    logic                  w_line_start;
    logic                  w_wr_en;
    logic                  w_wr_bank;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [WORD_W-1:0]     w_wr_data;

    assign w_in_ce      = CLK_6M_I & ~r_prev_6m;
    assign w_line_start = w_in_ce & HSYNC_I & ~r_prev_hs;

    // Pixels are stored on every other input strobe. A line start is always a
    // write slot, so pixel 0 of a line goes to address 0 of the new bank and
    // the alternation restarts from there. Before the first line start after
    // reset nothing is written, so the partial line around reset is never
    // shown and the first line start loads a zero line length.
    assign w_wr_en   = w_in_ce & (w_line_start | (r_line_seen & ~r_wr_phase));
    assign w_wr_bank = w_line_start ? ~r_wr_bank : r_wr_bank;
    assign w_wr_addr = w_line_start ? '0 : r_wr_x;
    assign w_wr_data = {HBLANK_I, R_I, G_I, B_I};

    always_ff @(posedge CLK_48M or posedge RST) begin
        if (RST) begin
            r_prev_6m   <= 1'b0;
            r_prev_hs   <= 1'b0;
            r_wr_phase  <= 1'b0;
            r_line_seen <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_x      <= '0;
            r_line_len  <= '0;
            r_vsync     <= 1'b0;
            r_vblank    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_prev_6m <= CLK_6M_I;
            if (w_in_ce) begin
                r_prev_hs  <= HSYNC_I;
                r_wr_phase <= w_wr_en;
            end
            if (w_line_start) begin
                r_line_seen <= 1'b1;
                r_line_len  <= r_wr_x;
                r_wr_x      <= ADDR_WIDTH'(1);
                r_wr_bank   <= ~r_wr_bank;
                r_vsync     <= VSYNC_I;
                r_vblank    <= VBLANK_I;
            end else if (w_wr_en && (r_wr_x != ADDR_LAST)) begin
                r_wr_x <= r_wr_x + 1'b1;
            end
            // At the last address the pointer holds, so later pixels of an
            // over-long line keep overwriting that final location.
            if (w_wr_en && (w_wr_addr == ADDR_LAST)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Line buffer: both banks in one simple dual-port array, bank bit on top
    // ---------------------------------------------------------------------
    logic [WORD_W-1:0] r_mem [0:2*DEPTH-1];
    logic [WORD_W-1:0] r_rd_word;

    logic [1:0]            r_out_div;
    logic [ADDR_WIDTH-1:0] r_rd_x;
    logic                  w_pix_ce;
    logic                  w_line_empty;

    assign w_pix_ce     = (r_out_div == 2'd3);
    assign w_line_empty = (r_line_len == '0);

    always_ff @(posedge CLK_48M) begin
        if (w_wr_en) begin
            r_mem[{w_wr_bank, w_wr_addr}] <= w_wr_data;
        end
        if (w_pix_ce) begin
            r_rd_word <= r_mem[{~r_wr_bank, r_rd_x}];
        end
    end

    // ---------------------------------------------------------------------
    // Output side. A strobe reads the RAM (stage 1); the cycle after, the
    // word and the flags captured alongside it load the output registers.
    // Which of the two passes over a stored line is playing does not change
    // any output, so no register tracks it: the read pointer simply wraps
    // over line_len until the next line start.
    // ---------------------------------------------------------------------
    logic             r_s1_valid;
    logic             r_s1_hsync;
    logic             r_s1_blank;
    logic             r_hsync_out;
    logic             r_blank_out;
    logic [RGB_WIDTH-1:0] r_r_out;
    logic [RGB_WIDTH-1:0] r_g_out;
    logic [RGB_WIDTH-1:0] r_b_out;
    logic             w_pix_blank;

    assign w_pix_blank = r_s1_blank | r_rd_word[WORD_W-1];

    always_ff @(posedge CLK_48M or posedge RST) begin
        if (RST) begin
            r_out_div   <= 2'd0;
            r_rd_x      <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_hsync  <= 1'b0;
            r_s1_blank  <= 1'b0;
            r_hsync_out <= 1'b0;
            r_blank_out <= 1'b0;
            r_r_out     <= '0;
            r_g_out     <= '0;
            r_b_out     <= '0;
        end else begin
            // A line start restarts the output raster. A strobe landing in
            // that same cycle still completes: it is the last pixel of the
            // line being shown, so it uses the old bank, length and vblank.
            r_out_div <= w_line_start ? 2'd0 : r_out_div + 2'd1;

            if (w_line_start) begin
                r_rd_x <= '0;
            end else if (w_pix_ce) begin
                if (w_line_empty || (r_rd_x == r_line_len - 1'b1)) begin
                    r_rd_x <= '0;
                end else begin
                    r_rd_x <= r_rd_x + 1'b1;
                end
            end

            r_s1_valid <= w_pix_ce;
            if (w_pix_ce) begin
                r_s1_hsync <= ~w_line_empty && ({1'b0, r_rd_x} < HS_LEN);
                r_s1_blank <= r_vblank | w_line_empty;
            end

            if (r_s1_valid) begin
                r_hsync_out <= r_s1_hsync;
                r_blank_out <= w_pix_blank;
                r_r_out     <= w_pix_blank ? '0 : r_rd_word[3*RGB_WIDTH-1:2*RGB_WIDTH];
                r_g_out     <= w_pix_blank ? '0 : r_rd_word[2*RGB_WIDTH-1:RGB_WIDTH];
                r_b_out     <= w_pix_blank ? '0 : r_rd_word[RGB_WIDTH-1:0];
            end
        end
    end

    assign R_O        = r_r_out;
    assign G_O        = r_g_out;
    assign B_O        = r_b_out;
    assign HSYNC_O    = r_hsync_out;
    assign VSYNC_O    = r_vsync;
    assign BLANK_O    = r_blank_out;
    assign PIX_CE_O   = w_pix_ce;
    assign OVERFLOW_O = r_overflow;

endmodule

// File: tb/tb_scan_doubler.sv
// -----------------------------------------------------------------------------
// tb_scan_doubler
//
// Drives native lines (one pixel slot = 8 CLK_48M: two CLK_6M_I rising edges,
// the first of which stores the pixel) and compares every cycle's outputs
// with a reference computed from the line history: the time since the last
// line start gives the output strobe index, which selects a pixel of the
// previously captured line.
// -----------------------------------------------------------------------------
module tb_scan_doubler;

    logic       CLK_48M  = 1'b0;
    logic       RST      = 1'b0;
    logic       CLK_6M_I = 1'b0;
    logic       HSYNC_I  = 1'b0;
    logic       VSYNC_I  = 1'b0;
    logic       HBLANK_I = 1'b0;
    logic       VBLANK_I = 1'b0;
    logic [3:0] R_I = '0, G_I = '0, B_I = '0;
    logic [3:0] R_O, G_O, B_O;
    logic       HSYNC_O, VSYNC_O, BLANK_O, PIX_CE_O, OVERFLOW_O;

    scan_doubler #(.RGB_WIDTH(4), .ADDR_WIDTH(9), .OUT_HSYNC_LEN(32)) dut (
        .CLK_48M(CLK_48M), .RST(RST), .CLK_6M_I(CLK_6M_I),
        .HSYNC_I(HSYNC_I), .VSYNC_I(VSYNC_I), .HBLANK_I(HBLANK_I), .VBLANK_I(VBLANK_I),
        .R_I(R_I), .G_I(G_I), .B_I(B_I),
        .R_O(R_O), .G_O(G_O), .B_O(B_O),
        .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O), .BLANK_O(BLANK_O),
        .PIX_CE_O(PIX_CE_O), .OVERFLOW_O(OVERFLOW_O)
    );

    always #5 CLK_48M = ~CLK_48M;

    int    cyc       = 0;
    int    n_checks  = 0;
    int    n_errors  = 0;
    string phase     = "reset";
    bit    in_reset  = 1'b0;

    // Line history since the last reset.
    int         n_lines   = 0;
    int         ln_start [0:31];
    int         ln_len   [0:31];
    bit         ln_vb    [0:31];
    bit         ln_vs    [0:31];
    logic [12:0] ln_pix  [0:31][0:599];
    int         ovf_cycle = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Expected {PIX_CE, HSYNC, VSYNC, BLANK, OVERFLOW, R, G, B} in cycle t.
    // Returns 0 where the outputs still depend on pre-line-start activity.
    function automatic bit model_out(input int t, output logic [16:0] exp);
        int n, m, u, d, s, k, len_shown, p;
        logic [12:0] w;
        bit blank;
        exp = '0;
        if (n_lines == 0 || t <= ln_start[0]) return 1'b0;
        n = 0;
        for (int i = 1; i < n_lines; i++) if (ln_start[i] < t) n = i;
        exp[16] = ((t - ln_start[n]) % 4) == 0;
        exp[14] = ln_vs[n];
        exp[12] = (ovf_cycle >= 0) && (t > ovf_cycle);
        // Outputs show the most recent strobe at least two cycles old.
        u = t - 2;
        if (u <= ln_start[0]) return 1'b0;
        m = 0;
        for (int i = 1; i < n_lines; i++) if (ln_start[i] < u) m = i;
        d = u - ln_start[m];
        if (d < 4) begin
            // The strobe coinciding with a line start ends the previous period.
            s = ln_start[m];
            m = m - 1;
            if (m < 0) return 1'b0;
        end else begin
            s = ln_start[m] + 4 * (d / 4);
        end
        k = (s - ln_start[m] - 4) / 4;
        len_shown = (m == 0) ? 0 : ((ln_len[m-1] > 511) ? 511 : ln_len[m-1]);
        if (len_shown == 0) begin
            exp[13] = 1'b1;
        end else begin
            p = k % len_shown;
            w = ln_pix[m-1][p];
            blank = w[12] | ln_vb[m];
            exp[13] = blank;
            exp[15] = (p < 32);
            if (!blank) exp[11:0] = w[11:0];
        end
        return 1'b1;
    endfunction

    task automatic sample();
        logic [16:0] act, exp;
        act = {PIX_CE_O, HSYNC_O, VSYNC_O, BLANK_O, OVERFLOW_O, R_O, G_O, B_O};
        if (in_reset) check_eq(phase, {15'd0, act}, 32'd0);
        else if (model_out(cyc, exp)) check_eq(phase, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic tick(input bit c6);
        @(posedge CLK_48M);
        #1;
        cyc++;
        CLK_6M_I = c6;
        @(negedge CLK_48M);
        sample();
    endtask

    task automatic drive_idle(input int slots);
        HSYNC_I = 1'b0; VSYNC_I = 1'b0; HBLANK_I = 1'b1; VBLANK_I = 1'b0;
        for (int j = 0; j < slots * 8; j++) tick((j % 4) < 2);
    endtask

    // mode 0: random colour, 1: R = pixel index, 2: single red pixel at x = 10.
    // stop_at >= 0 abandons the line before that pixel.
    task automatic drive_line(input int len, input bit vb, input bit vs, input int mode, input int stop_at);
        int idx;
        logic [3:0] r, g, b;
        logic hb;
        idx = n_lines;
        ln_len[idx] = len;
        ln_vb[idx]  = vb;
        ln_vs[idx]  = vs;
        for (int i = 0; i < len; i++) begin
            if (i == stop_at) return;
            hb = (i >= (len * 3) / 4);
            case (mode)
                1:       begin r = i[3:0]; g = 4'($urandom_range(15, 0)); b = 4'($urandom_range(15, 0)); end
                2:       begin r = (i == 10) ? 4'hF : 4'h0; g = 4'h0; b = 4'h0; end
                default: begin r = 4'($urandom_range(15, 0)); g = 4'($urandom_range(15, 0)); b = 4'($urandom_range(15, 0)); end
            endcase
            HSYNC_I = (i < 16); VSYNC_I = vs; VBLANK_I = vb; HBLANK_I = hb;
            R_I = r; G_I = g; B_I = b;
            ln_pix[idx][i] = {hb, r, g, b};
            for (int sub = 0; sub < 8; sub++) begin
                tick((sub % 4) < 2);
                if (sub == 0) begin
                    if (i == 0) begin
                        ln_start[idx] = cyc;
                        n_lines = idx + 1;
                    end
                    if (i == 511 && ovf_cycle < 0) ovf_cycle = cyc;
                end
            end
        end
    endtask

    task automatic release_reset();
        @(posedge CLK_48M);
        #1;
        cyc++;
        RST = 1'b0;
        in_reset = 1'b0;
        n_lines = 0;
        ovf_cycle = -1;
        @(negedge CLK_48M);
    endtask

    initial begin
        logic [16:0] act;
        #2 RST = 1'b1;
        in_reset = 1'b1;
        for (int j = 0; j < 4; j++) tick(1'b0);
        release_reset();
        drive_idle(5);

        phase = "steady";
        drive_line(384, 1'b0, 1'b1, 1, -1);
        drive_line(384, 1'b0, 1'b0, 1, -1);
        drive_line(384, 1'b0, 1'b0, 0, -1);
        phase = "latency";
        drive_line(384, 1'b0, 1'b0, 2, -1);
        phase = "vblank";
        drive_line(384, 1'b1, 1'b1, 0, -1);
        drive_line(384, 1'b0, 1'b0, 0, -1);
        phase = "overflow";
        drive_line(600, 1'b0, 1'b0, 0, -1);
        drive_line(384, 1'b0, 1'b0, 1, -1);
        phase = "resync";
        drive_line(380, 1'b0, 1'b0, 0, -1);
        drive_line(384, 1'b0, 1'b0, 0, -1);
        drive_line(384, 1'b0, 1'b0, 0, 200);

        // Reset in the middle of an active line.
        phase = "reset_mid";
        @(posedge CLK_48M);
        #3;
        cyc++;
        RST = 1'b1;
        in_reset = 1'b1;
        #1;
        act = {PIX_CE_O, HSYNC_O, VSYNC_O, BLANK_O, OVERFLOW_O, R_O, G_O, B_O};
        check_eq("rst_async", {15'd0, act}, 32'd0);
        CLK_6M_I = 1'b0;
        @(negedge CLK_48M);
        for (int j = 0; j < 3; j++) tick(1'b0);
        release_reset();

        phase = "after_rst";
        drive_idle(3);
        drive_line(384, 1'b0, 1'b1, 0, -1);
        drive_line(384, 1'b0, 1'b0, 1, -1);
        drive_line(384, 1'b0, 1'b0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
